nios_system_com_nios_div_cell: RTL and testbench
================================================

# nios_system_com_nios_div_cell

Iterative 32-bit integer divide cell for the Nios II custom arithmetic path; it provides the divide counterpart to the existing 32x32 multiply cell. It accepts a dividend/divisor pair on a start strobe and runs one radix-2 restoring step per clock. It then returns quotient and remainder with a one-cycle done pulse. Signed and unsigned operation is selected per request.

## Interface
- WIDTH, 32, operand and result width; only 32 is supported.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- A_div_src1  in  32  dividend; sampled on the accepted start.
- A_div_src2  in  32  divisor; sampled on the accepted start.
- A_div_signed  in  1  1 selects two's-complement operation, 0 selects unsigned; sampled on the accepted start.
- A_div_start  in  1  request strobe; accepted only when A_div_busy is 0.
- A_div_busy  out  1  high while a division is in progress (PREP, ITER, FIX).
- A_div_done  out  1  single-cycle pulse; results are valid in the same cycle.
- A_div_quotient  out  32  quotient register.
- A_div_remainder  out  32  remainder register.
- A_div_by_zero  out  1  set with done when the divisor was 0; cleared on the next accepted start.

## Operation
- FSM states: IDLE, PREP, ITER, FIX, DONE.
- IDLE or DONE with start=1: latch the operands and the signed flag, go to PREP, drive busy=1. With start=0, DONE returns to IDLE.
- PREP:
  - If the divisor is 0, load quotient=0xFFFFFFFF and remainder=dividend (raw), set by_zero, and go to DONE, skipping ITER and FIX.
  - Otherwise, in signed mode, take the magnitudes of both operands and record sign_q = s1^s2 and sign_r = s1. Clear the partial remainder and the counter, then go to ITER.
- ITER: 32 cycles, counter 0..31.
  - Each step: shift {rem,dividend} left by 1 and trial-subtract the divisor magnitude.
  - If there is no borrow, keep the difference and shift in a quotient bit of 1; otherwise restore and shift in 0.
  - At count 31, go to FIX.
- FIX: in signed mode, negate the quotient if sign_q and negate the remainder if sign_r. This gives a truncating quotient, with the remainder taking the sign of the dividend. Write the result registers, then go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle.
- The result registers hold their values until the next done.
- Overflow: 0x80000000 / 0xFFFFFFFF in signed mode yields quotient 0x80000000, remainder 0. No flag is raised.
- start while busy=1 is ignored and has no side effects.
- reset at any point: return to IDLE. All outputs go to 0, and no done pulse is issued for the aborted request.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, by_zero=0.
- Normal latency: start sampled at edge E0, then PREP at E1, ITER at E2..E33, FIX at E34. done is high for the cycle following E34 (35 cycles after start).
- Divide-by-zero latency: done is high for the cycle following E1 (2 cycles after start).
- Back-to-back: start asserted in the DONE cycle is accepted, so there is no idle bubble. The throughput is one result per 35 cycles.
- Latency does not depend on the signed setting or on the operand values, apart from the divide-by-zero early exit.

## Configuration
- NIOS_DIV_SIGNED_EN defined: signed support is built (magnitude logic, sign registers, FIX negation), and A_div_signed is honoured.
- NIOS_DIV_SIGNED_EN undefined:
  - A_div_signed is ignored and all operation is unsigned.
  - The negators and sign registers are not built.
  - The FIX state is kept as a pass-through cycle, so latency is identical in both builds.

## Structure
- Package nios_system_com_nios_div_pkg holds:
  - the state enum (IDLE, PREP, ITER, FIX, DONE);
  - DIV_ITERATIONS=32;
  - DIV_BY_ZERO_QUOT=32'hFFFFFFFF.
- Sub-module nios_system_com_nios_div_step: purely combinational single restoring step. Inputs are partial remainder, next dividend bit and divisor. Outputs are the new partial remainder and the quotient bit.

## Test plan
- Unsigned 100/7 -> quotient 14, remainder 2, done exactly 35 cycles after start, busy high for 34 cycles.
- Signed -7/2 (0xFFFFFFF9/2) -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). The same operands in unsigned mode -> quotient 0x7FFFFFFC, remainder 1.
- Divisor 0 with dividend 0x12345678 -> quotient 0xFFFFFFFF, remainder 0x12345678, by_zero=1, done 2 cycles after start.
- Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, by_zero=0.
- start pulsed at cycle 10 of a busy division -> ignored; the first result is unchanged and only one done occurs. A start in the DONE cycle is accepted.
- reset asserted at ITER count 15 -> next cycle busy=0, quotient=0, remainder=0, and no done pulse. A subsequent 9/3 request returns quotient 3, remainder 0.

Source files
------------

// File: rtl/nios_system_com_nios_div_pkg.sv
// Shared types and constants for the Nios II iterative divide cell.
// NIOS_DIV_SIGNED_EN enables two's-complement support in the cell.
package nios_system_com_nios_div_pkg;

    localparam int          DIV_ITERATIONS   = 32;
    localparam logic [31:0] DIV_BY_ZERO_QUOT = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } div_state_e;

endpackage

// File: rtl/nios_system_com_nios_div_step.sv
// One radix-2 restoring division step, purely combinational.
module nios_system_com_nios_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;

    // rem_i < dsr_i always holds, so the difference fits a signed WIDTH+1 word
    assign sh    = {rem_i, bit_i};
    assign diff  = sh - {1'b0, dsr_i};
    assign q_o   = ~diff[WIDTH];
    assign rem_o = q_o ? diff[WIDTH-1:0] : sh[WIDTH-1:0];

endmodule

// File: rtl/nios_system_com_nios_div_cell.sv
// Iterative 32-bit divide cell, one restoring step per clock.
// Signed support is built only when NIOS_DIV_SIGNED_EN is defined.
module nios_system_com_nios_div_cell
    import nios_system_com_nios_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A_div_src1,
    input  logic [WIDTH-1:0] A_div_src2,
    input  logic             A_div_signed,
    input  logic             A_div_start,
    output logic             A_div_busy,
    output logic             A_div_done,
    output logic [WIDTH-1:0] A_div_quotient,
    output logic [WIDTH-1:0] A_div_remainder,
    output logic             A_div_by_zero
);

    localparam int CW = $clog2(DIV_ITERATIONS);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             byz_q, byz_d;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

`ifdef NIOS_DIV_SIGNED_EN
    logic sgn_q, sgn_d;
    logic sq_q, sq_d;
    logic sr_q, sr_d;
`else
    logic unused_signed;
    assign unused_signed = A_div_signed;
`endif

    nios_system_com_nios_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[WIDTH-1]),
        .dsr_i (dsr_q),
        .rem_o (step_rem),
        .q_o   (step_bit)
    );

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        remd_d  = remd_q;
        cnt_d   = cnt_q;
        byz_d   = byz_q;
`ifdef NIOS_DIV_SIGNED_EN
        sgn_d   = sgn_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (A_div_start) begin
                    state_d = PREP;
                    dvd_d   = A_div_src1;
                    dsr_d   = A_div_src2;
                    byz_d   = 1'b0;
`ifdef NIOS_DIV_SIGNED_EN
                    sgn_d   = A_div_signed;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            PREP: begin
                if (dsr_q == '0) begin
                    quot_d  = DIV_BY_ZERO_QUOT;
                    remd_d  = dvd_q;
                    byz_d   = 1'b1;
                    state_d = DONE;
                end else begin
`ifdef NIOS_DIV_SIGNED_EN
                    if (sgn_q && dvd_q[WIDTH-1]) dvd_d = -dvd_q;
                    if (sgn_q && dsr_q[WIDTH-1]) dsr_d = -dsr_q;
                    sq_d = sgn_q & (dvd_q[WIDTH-1] ^ dsr_q[WIDTH-1]);
                    sr_d = sgn_q & dvd_q[WIDTH-1];
`endif
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                // dividend register doubles as the quotient shift register
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DIV_ITERATIONS - 1)) state_d = FIX;
            end
            FIX: begin
`ifdef NIOS_DIV_SIGNED_EN
                quot_d = sq_q ? -dvd_q : dvd_q;
                remd_d = sr_q ? -rem_q : rem_q;
`else
                quot_d = dvd_q;
                remd_d = rem_q;
`endif
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            remd_q  <= '0;
            cnt_q   <= '0;
            byz_q   <= 1'b0;
`ifdef NIOS_DIV_SIGNED_EN
            sgn_q   <= 1'b0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            cnt_q   <= cnt_d;
            byz_q   <= byz_d;
`ifdef NIOS_DIV_SIGNED_EN
            sgn_q   <= sgn_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
`endif
        end
    end

    assign A_div_busy      = (state_q == PREP) || (state_q == ITER)
                           || (state_q == FIX);
    assign A_div_done      = (state_q == DONE);
    assign A_div_quotient  = quot_q;
    assign A_div_remainder = remd_q;
    assign A_div_by_zero   = byz_q;

endmodule

// File: tb/tb_nios_system_com_nios_div_cell.sv
// Scoreboard bench for the iterative divide cell.
module tb_nios_system_com_nios_div_cell;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
        int          t0;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        sgn = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, byz;
    logic [31:0] quot, remd;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   busy_cnt;
    int   got_done;

    nios_system_com_nios_div_cell dut (
        .clk             (clk),
        .reset           (reset),
        .A_div_src1      (src1),
        .A_div_src2      (src2),
        .A_div_signed    (sgn),
        .A_div_start     (start),
        .A_div_busy      (busy),
        .A_div_done      (done),
        .A_div_quotient  (quot),
        .A_div_remainder (remd),
        .A_div_by_zero   (byz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, req);
    endtask

    // monitor: pop and compare on every done pulse
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done=1 want no done");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_quot"}, quot, e.q);
                chk({e.name, "_rem"}, remd, e.r);
                chk({e.name, "_byz"}, {31'b0, byz}, {31'b0, e.z});
                chk({e.name, "_lat"}, cyc - e.t0, e.lat);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] eq,
                         input logic [31:0] er, input logic ez,
                         input int lat, input string nm, input bit push);
        exp_t e;
        src1  = a;
        src2  = b;
        sgn   = s;
        start = 1'b1;
        if (push) begin
            e.q = eq; e.r = er; e.z = ez; e.lat = lat;
            e.t0 = cyc; e.name = nm;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        busy_cnt = 0;
        got_done = 0;
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) begin
                got_done = 1;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        if (got_done == 0) begin
            n_total++;
            $display("FAIL %s_timeout: got no done want done", nm);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_quot", quot, 32'd0);
        chk("rst_rem", remd, 32'd0);
        chk("rst_byz", {31'b0, byz}, 32'd0);

        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 35, "u100_7", 1);
        wait_done("u100_7");
        chk("u100_7_busy_cycles", busy_cnt, 34);
        @(negedge clk);
        chk("idle_after_done", {31'b0, done}, 32'd0);

`ifdef NIOS_DIV_SIGNED_EN
        issue(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF,
              1'b0, 35, "s_m7_2", 1);
`else
        issue(32'hFFFFFFF9, 32'd2, 1'b1, 32'h7FFFFFFC, 32'd1,
              1'b0, 35, "s_m7_2", 1);
`endif
        wait_done("s_m7_2");
        @(negedge clk);

        issue(32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1,
              1'b0, 35, "u_m7_2", 1);
        wait_done("u_m7_2");
        @(negedge clk);

`ifdef NIOS_DIV_SIGNED_EN
        issue(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,
              1'b0, 35, "s_7_m2", 1);
`else
        issue(32'd7, 32'hFFFFFFFE, 1'b1, 32'd0, 32'd7,
              1'b0, 35, "s_7_m2", 1);
`endif
        wait_done("s_7_m2");
        @(negedge clk);

        issue(32'h12345678, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678,
              1'b1, 2, "div0", 1);
        wait_done("div0");
        @(negedge clk);

`ifdef NIOS_DIV_SIGNED_EN
        issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,
              1'b0, 35, "ovf", 1);
`else
        issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 32'h80000000,
              1'b0, 35, "ovf", 1);
`endif
        wait_done("ovf");
        @(negedge clk);

        // start while busy is ignored; start in DONE cycle is taken
        issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 35,
              "busy_ign", 1);
        repeat (9) @(negedge clk);
        src1  = 32'd5;
        src2  = 32'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ign");
        issue(32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 1'b0, 35, "b2b", 1);
        wait_done("b2b");
        repeat (3) @(negedge clk);

        // reset in the middle of ITER aborts with no done
        issue(32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 0, "abort", 0);
        repeat (16) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_quot", quot, 32'd0);
        chk("abort_rem", remd, 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        issue(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 35, "u9_3", 1);
        wait_done("u9_3");
        repeat (3) @(negedge clk);

        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL sb_empty: got %0d left want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
